fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 89 ++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FWFT FIFO drain into a 2-entry (out + skid) valid/ready stream.
// Optional delivery counter enabled by FIFO_READER_WORD_COUNT_EN.
module fifo_reader #(
  parameter type DATA_TYPE = logic [1:0],
  parameter int  CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                fifo_empty,
  input  DATA_TYPE            fifo_rd_data,
  output logic                fifo_rd_en,
  output logic                out_valid,
  output DATA_TYPE            out_data,
  input  logic                out_ready,
  output logic [CNT_BITS-1:0] word_count
);

  typedef enum logic [1:0] {S0, S1, S2} state_t;

  state_t   state, state_nxt;
  DATA_TYPE skid;
  logic     pop, deliver;
  logic     load_out_fifo, load_out_skid, load_skid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load_out_fifo = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    // Reset gates the pop strobe so the FIFO never loses a word while we are held clear.
    pop     = en & ~fifo_empty & (state != S2) & ~reset;
    deliver = (state != S0) & out_ready;
    case (state)
      S0: begin
        if (pop) begin
          state_nxt     = S1;
          load_out_fifo = 1'b1;
        end
      end
      S1: begin
        if (pop && deliver) begin
          load_out_fifo = 1'b1;
        end else if (pop) begin
          state_nxt = S2;
          load_skid = 1'b1;
        end else if (deliver) begin
          state_nxt = S0;
        end
      end
      S2: begin
        if (deliver) begin
          state_nxt     = S1;
          load_out_skid = 1'b1;
        end
      end
      default: state_nxt = S0;
    endcase
  end

  assign fifo_rd_en = pop;
  assign out_valid  = (state != S0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      skid     <= '0;
    end else begin
      if (load_out_fifo)      out_data <= fifo_rd_data;
      else if (load_out_skid) out_data <= skid;
      if (load_skid)          skid     <= fifo_rd_data;
    end
  end

`ifdef FIFO_READER_WORD_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        word_count <= '0;
    else if (deliver) word_count <= word_count + 1'b1;
  end
`else
  assign word_count = '0;
`endif

endmodule
